// File: rtl/uart_rx_if.sv
// Receive-side result bus of the UART: the held character, its qualifying
// error flags, the one-cycle completion strobe and the busy indication.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    // Receiver drives the bus
    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output busy
    );

    // Consumer of received characters
    modport slave (
        input rx_data,
        input rx_valid,
        input parity_err,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART serial receiver: two-flop synchronizer followed by a mid-bit sampling
// FSM. Frames are idle-high, one start bit, data LSB first, optional parity,
// one stop bit. Each completed frame produces a one-cycle rx_valid with the
// character and its error flags held until the next frame completes.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  S_IDLE   | line idle, waiting for rx_s to fall
//  S_START  | counting to mid start bit, rejecting glitches
//  S_DATA   | sampling DATA_BITS data bits at mid-bit
//  S_PARITY | sampling the parity bit, result kept as a pending flag
//  S_STOP   | sampling the stop bit, then publishing the frame next cycle
//  S_BREAK  | stop bit was 0; waiting for the line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    uart_rx_if.master  rx_bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          ODD_BIT  = (PARITY_ODD != 0);
    localparam logic          PAR_ON   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [CW-1:0]        clk_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 par_pend_q;
    logic                 par_pend_d;
    logic                 stop_bit_q;
    logic                 stop_seen_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 busy_q;

    assign rx_s = sync_q[1];

    // New sampled bit enters at the MSB so the character ends up LSB-aligned
    assign shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
    assign par_pend_d = (^shift_q) ^ rx_s ^ ODD_BIT;

    // Two-flop synchronizer for the asynchronous line, reset to idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_in};
        end
    end

    // Receive FSM with counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_pend_q   <= 1'b0;
            stop_bit_q   <= 1'b1;
            stop_seen_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q     <= S_START;
                        clk_cnt_q   <= '0;
                        par_pend_q  <= 1'b0;
                        stop_seen_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end

                S_START: begin
                    if (clk_cnt_q == HALF_M1) begin
                        clk_cnt_q <= '0;
                        if (!rx_s) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            // Start bit gone by mid-bit: line glitch, not a frame
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end

                S_DATA: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q <= '0;
                        shift_q   <= shift_d;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= PAR_ON ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end

                S_PARITY: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q  <= '0;
                        par_pend_q <= par_pend_d;
                        state_q    <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end

                S_STOP: begin
                    if (stop_seen_q) begin
                        // Publish one cycle after the stop sample
                        stop_seen_q  <= 1'b0;
                        rx_data_q    <= shift_q;
                        parity_err_q <= PAR_ON & par_pend_q;
                        frame_err_q  <= ~stop_bit_q;
                        rx_valid_q   <= 1'b1;
                        if (stop_bit_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_BREAK;
                        end
                    end else if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q   <= '0;
                        stop_bit_q  <= rx_s;
                        stop_seen_q <= 1'b1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end

                S_BREAK: begin
                    // A line held low must return high before a new start counts
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.rx_data    = rx_data_q;
    assign rx_bus.rx_valid   = rx_valid_q;
    assign rx_bus.parity_err = parity_err_q;
    assign rx_bus.frame_err  = frame_err_q;
    assign rx_bus.busy       = busy_q;

endmodule
